// File: rtl/seg_scan.sv
// Multiplexed hex 7-segment scanner driven by segclk rising edges.
// Display values are double-buffered and swap in only at a frame wrap.
module seg_scan #(
    parameter int NDIG       = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              segclk,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits_in,
    input  logic [NDIG-1:0]   blank_in,
    input  logic [NDIG-1:0]   dp_in,
    output logic              load_ack,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int            IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
    localparam logic          INV  = (ACTIVE_LOW != 0);

    // Active-high {g..a} pattern for one hex nibble.
    function automatic logic [6:0] hexdec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1101111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            4'hF:    s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic              segclk_d_r;
    logic [IW-1:0]     idx_r;
    logic [4*NDIG-1:0] stg_dig_r, act_dig_r;
    logic [NDIG-1:0]   stg_blk_r, act_blk_r;
    logic [NDIG-1:0]   stg_dp_r, act_dp_r;
    logic              pending_r;
    logic              ack_r;
    logic [NDIG-1:0]   an_r;
    logic [6:0]        seg_r;
    logic              dp_r;

    logic              tick_s;
    logic              wrap_s;
    logic              commit_s;
    logic              cur_blank_s;
    logic [3:0]        cur_digit_s;
    logic [NDIG-1:0]   onehot_s;
    logic [NDIG-1:0]   an_nxt_s;
    logic [6:0]        seg_nxt_s;
    logic              dp_nxt_s;

    // Edge detect, frame wrap and commit decode.
    always_comb begin
        tick_s      = segclk & ~segclk_d_r;
        wrap_s      = tick_s & (idx_r == LAST);
        commit_s    = wrap_s & pending_r;
        cur_blank_s = act_blk_r[idx_r];
        cur_digit_s = act_dig_r[4*idx_r +: 4];
        onehot_s    = {{(NDIG-1){1'b0}}, 1'b1} << idx_r;
    end

    // Next output values, active-high; anodes stay dark for one cycle after each tick.
    always_comb begin
        an_nxt_s  = {NDIG{1'b0}};
        seg_nxt_s = 7'b0000000;
        dp_nxt_s  = 1'b0;
        if (cur_blank_s) begin
            an_nxt_s  = {NDIG{1'b0}};
            seg_nxt_s = 7'b0000000;
            dp_nxt_s  = 1'b0;
        end else begin
            seg_nxt_s = hexdec(cur_digit_s);
            dp_nxt_s  = act_dp_r[idx_r];
            if (tick_s) begin
                an_nxt_s = {NDIG{1'b0}};
            end else begin
                an_nxt_s = onehot_s;
            end
        end
    end

    // Edge-detect history and scan index.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            segclk_d_r <= 1'b0;
            idx_r      <= {IW{1'b0}};
        end else begin
            segclk_d_r <= segclk;
            if (tick_s) begin
                idx_r <= wrap_s ? {IW{1'b0}} : idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Staging buffer; a load coinciding with a commit stays pending for the next frame.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stg_dig_r <= {(4*NDIG){1'b0}};
            stg_blk_r <= {NDIG{1'b0}};
            stg_dp_r  <= {NDIG{1'b0}};
            pending_r <= 1'b0;
        end else if (load) begin
            stg_dig_r <= digits_in;
            stg_blk_r <= blank_in;
            stg_dp_r  <= dp_in;
            pending_r <= 1'b1;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end
    end

    // Active display buffer, swapped only at a frame wrap.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            act_dig_r <= {(4*NDIG){1'b0}};
            act_blk_r <= {NDIG{1'b1}};
            act_dp_r  <= {NDIG{1'b0}};
            ack_r     <= 1'b0;
        end else begin
            ack_r <= commit_s;
            if (commit_s) begin
                act_dig_r <= stg_dig_r;
                act_blk_r <= stg_blk_r;
                act_dp_r  <= stg_dp_r;
            end
        end
    end

    // Registered pin drive with board polarity applied.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an_r  <= {NDIG{INV}};
            seg_r <= {7{INV}};
            dp_r  <= INV;
        end else begin
            an_r  <= an_nxt_s ^ {NDIG{INV}};
            seg_r <= seg_nxt_s ^ {7{INV}};
            dp_r  <= dp_nxt_s ^ INV;
        end
    end

    assign load_ack = ack_r;
    assign an       = an_r;
    assign seg      = seg_r;
    assign dp       = dp_r;

endmodule

// File: tb/tb_seg_scan.sv
// Directed, table-driven bench for seg_scan (NDIG=4, active-low pins).
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        segclk;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blank_in;
    logic [3:0]  dp_in;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg_scan #(.NDIG(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .clr_n(clr_n), .segclk(segclk), .load(load),
        .digits_in(digits_in), .blank_in(blank_in), .dp_in(dp_in),
        .load_ack(load_ack), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      dig;
        logic [3:0]       blk;
        logic [3:0]       dpi;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
        logic [3:0]       dp;
    } vec_t;

    localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    vec_t vecs [5];
    vec_t v2222, v5555;
    int   n_pass = 0;
    int   n_total = 0;
    int   cur_idx = 0;
    int   ack_cnt = 0;
    int   ack_base;

    always @(negedge clk) if (load_ack === 1'b1) ack_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        @(negedge clk);
        load = 1'b1; digits_in = d; blank_in = b; dp_in = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    // One segclk pulse; returns at the negedge right after the tick edge.
    task automatic tick_and_check(input logic exp_ack);
        @(negedge clk) segclk = 1'b1;
        @(negedge clk) segclk = 1'b0;
        cur_idx = (cur_idx + 1) % 4;
        chk($sformatf("dead_an_idx%0d", cur_idx), 32'(an), 32'hF);
        chk($sformatf("ack_after_tick_idx%0d", cur_idx), 32'(load_ack), 32'(exp_ack));
    endtask

    task automatic check_disp(input int i, input vec_t v);
        @(negedge clk);
        chk($sformatf("an_idx%0d", i), 32'(an), 32'(v.an[i]));
        chk($sformatf("seg_idx%0d", i), 32'(seg), 32'(v.seg[i]));
        chk($sformatf("dp_idx%0d", i), 32'(dp), 32'(v.dp[i]));
        chk($sformatf("ack_low_idx%0d", i), 32'(load_ack), 32'h0);
    endtask

    task automatic wrap_frame(input logic exp_ack);
        while (cur_idx != 3) tick_and_check(1'b0);
        tick_and_check(exp_ack);
    endtask

    task automatic disp_frame(input vec_t v);
        check_disp(0, v);
        for (int i = 1; i < 4; i++) begin
            tick_and_check(1'b0);
            check_disp(i, v);
        end
    endtask

    initial begin
        vecs[0] = '{dig:16'h1A3F, blk:4'b0000, dpi:4'b0010, an:AN_ALL,
                    seg:{7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, dp:4'b1101};
        vecs[1] = '{dig:16'h0123, blk:4'b0000, dpi:4'b1000, an:AN_ALL,
                    seg:{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000}, dp:4'b0111};
        vecs[2] = '{dig:16'h4567, blk:4'b0000, dpi:4'b0000, an:AN_ALL,
                    seg:{7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}, dp:4'b1111};
        vecs[3] = '{dig:16'h89AB, blk:4'b0000, dpi:4'b0000, an:AN_ALL,
                    seg:{7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011}, dp:4'b1111};
        vecs[4] = '{dig:16'hCDEF, blk:4'b0100, dpi:4'b0001,
                    an:{4'b0111, 4'b1111, 4'b1101, 4'b1110},
                    seg:{7'b1000110, 7'b1111111, 7'b0000110, 7'b0001110}, dp:4'b1110};
        v2222 = '{dig:16'h2222, blk:4'b0000, dpi:4'b0000, an:AN_ALL,
                  seg:{4{7'b0100100}}, dp:4'b1111};
        v5555 = '{dig:16'h5555, blk:4'b0000, dpi:4'b0000, an:AN_ALL,
                  seg:{4{7'b0010010}}, dp:4'b1111};

        clr_n = 1'b0; segclk = 1'b0; load = 1'b0;
        digits_in = 16'h0000; blank_in = 4'b0000; dp_in = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_ack", 32'(load_ack), 32'h0);
        clr_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_an", 32'(an), 32'hF);
        chk("idle_seg", 32'(seg), 32'h7F);

        // Table: each record loads, commits at the next wrap, then is checked per digit.
        for (int k = 0; k < 5; k++) begin
            do_load(vecs[k].dig, vecs[k].blk, vecs[k].dpi);
            wrap_frame(1'b1);
            disp_frame(vecs[k]);
        end

        // Two loads mid-frame: last one wins, single ack.
        tick_and_check(1'b0);
        ack_base = ack_cnt;
        do_load(16'h1111, 4'b0000, 4'b0000);
        do_load(16'h2222, 4'b0000, 4'b0000);
        wrap_frame(1'b1);
        disp_frame(v2222);
        chk("single_ack", 32'(ack_cnt - ack_base), 32'h1);

        // Load coinciding with the commit of a pending value.
        do_load(16'h2222, 4'b0000, 4'b0000);
        while (cur_idx != 3) tick_and_check(1'b0);
        @(negedge clk);
        segclk = 1'b1; load = 1'b1; digits_in = 16'h5555; blank_in = 4'b0000; dp_in = 4'b0000;
        @(negedge clk);
        segclk = 1'b0; load = 1'b0;
        cur_idx = 0;
        chk("coincide_dead_an", 32'(an), 32'hF);
        chk("coincide_ack1", 32'(load_ack), 32'h1);
        disp_frame(v2222);
        wrap_frame(1'b1);
        disp_frame(v5555);

        // Asynchronous reset mid-frame drops the pending load.
        do_load(16'h7777, 4'b0000, 4'b0000);
        @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_dp", 32'(dp), 32'h1);
        chk("async_rst_ack", 32'(load_ack), 32'h0);
        @(negedge clk) clr_n = 1'b1;
        cur_idx = 0;
        tick_and_check(1'b0);
        wrap_frame(1'b0);
        @(negedge clk);
        chk("post_rst_an", 32'(an), 32'hF);
        chk("post_rst_seg", 32'(seg), 32'h7F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
